// File: rtl/lstm_pkg.sv
// -----------------------------------------------------------------------------
// lstm_pkg
// Shared types and constants for the LSTM sequencer slice.
//   DATA_WIDTH_DEF / FRACT_WIDTH_DEF : default Q8.8 word geometry
//   fx_t                             : signed fixed-point sample/state word
//   seq_state_t                      : sequencer state encoding
//   FX_ONE                           : 1.0 in Q8.8
// No ports (package).
// -----------------------------------------------------------------------------
package lstm_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRACT_WIDTH_DEF = 8;

    typedef logic signed [DATA_WIDTH_DEF-1:0] fx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WAIT   = 2'd2,
        EMIT   = 2'd3
    } seq_state_t;

    localparam fx_t FX_ONE = 16'h0100;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// lstm_seq_ctrl_if
// Bundles the control, sample stream, cell and h stream signals of
// lstm_seq_ctrl. Modports:
//   slave  : the sequencer itself
//   master : the environment (sample source, lstm_cell, h consumer)
// Signals:
//   start/seq_len           : sequence launch, length sampled on start
//   busy/done               : sequence status, done is a one-cycle pulse
//   x_valid/x_ready/x_data  : input sample stream
//   cell_x/cell_c/cell_h    : drive to lstm_cell inputs
//   cell_c_out/cell_h_out   : lstm_cell results
//   h_valid/h_ready/h_data/h_last : output h stream
//   dbg_state               : current sequencer state
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; the source holds valid and its data
// stable until that edge, and valid never depends on ready.
// -----------------------------------------------------------------------------
interface lstm_seq_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 8
);
    logic                  start;
    logic [LEN_W-1:0]      seq_len;
    logic                  busy;
    logic                  done;
    logic                  x_valid;
    logic                  x_ready;
    logic [DATA_WIDTH-1:0] x_data;
    logic [DATA_WIDTH-1:0] cell_x;
    logic [DATA_WIDTH-1:0] cell_c;
    logic [DATA_WIDTH-1:0] cell_h;
    logic [DATA_WIDTH-1:0] cell_c_out;
    logic [DATA_WIDTH-1:0] cell_h_out;
    logic                  h_valid;
    logic                  h_ready;
    logic [DATA_WIDTH-1:0] h_data;
    logic                  h_last;
    logic [1:0]            dbg_state;

    modport slave (
        input  start, seq_len, x_valid, x_data, cell_c_out, cell_h_out, h_ready,
        output busy, done, x_ready, cell_x, cell_c, cell_h,
               h_valid, h_data, h_last, dbg_state
    );

    modport master (
        output start, seq_len, x_valid, x_data, cell_c_out, cell_h_out, h_ready,
        input  busy, done, x_ready, cell_x, cell_c, cell_h,
               h_valid, h_data, h_last, dbg_state
    );

endinterface

// File: rtl/lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lstm_seq_ctrl
// Runs one combinational lstm_cell over a sequence of Q8.8 samples: takes a
// sample, holds it on the cell with the current c/h state, waits CELL_LAT
// cycles for the cell to settle, captures c_out/h_out as the new state and
// emits h.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : lstm_seq_ctrl_if.slave (start/seq_len/busy/done, x stream,
//          cell drive and results, h stream, dbg_state)
//
// Parameters: DATA_WIDTH, FRACT_WIDTH (informational), LEN_W, CELL_LAT (>=1).
//
// Build option: define LSTM_LAST_ONLY_EN to emit only the final step's h;
// intermediate steps then go straight from WAIT back to ACCEPT.
// -----------------------------------------------------------------------------
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DEF,
    parameter int LEN_W       = 8,
    parameter int CELL_LAT    = 2
) (
    input  logic           clk,
    input  logic           rst,
    lstm_seq_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCEPT = ACCEPT;
    localparam logic [1:0] ST_WAIT   = WAIT;
    localparam logic [1:0] ST_EMIT   = EMIT;

    // The wait counter counts down from CELL_LAT-1 to 0, so WAIT lasts
    // exactly CELL_LAT cycles.
    localparam int              WAIT_W    = (CELL_LAT > 1) ? $clog2(CELL_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CELL_LAT - 1);

    generate
        if (CELL_LAT < 1 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_params
            $error("lstm_seq_ctrl: CELL_LAT must be >= 1 and FRACT_WIDTH <= DATA_WIDTH");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_c;
    logic [DATA_WIDTH-1:0] r_h;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_t;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_done;

    logic                  w_t_last;
    logic                  w_emit;

    // r_len is never 0 outside IDLE, so len-1 cannot underflow where it matters.
    assign w_t_last = (r_t == (r_len - LEN_W'(1)));
    assign w_emit   = (r_state == ST_EMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_c     <= '0;
            r_h     <= '0;
            r_len   <= '0;
            r_t     <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.seq_len != '0) begin
                            r_len   <= bus.seq_len;
                            r_c     <= '0;
                            r_h     <= '0;
                            r_t     <= '0;
                            r_state <= ST_ACCEPT;
                        end else begin
                            // Empty sequence completes immediately.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (bus.x_valid) begin
                        r_x     <= bus.x_data;
                        r_wait  <= WAIT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        // Cell has settled on r_x/r_c/r_h: commit its outputs.
                        r_c <= bus.cell_c_out;
                        r_h <= bus.cell_h_out;
`ifdef LSTM_LAST_ONLY_EN
                        if (w_t_last) begin
                            r_state <= ST_EMIT;
                        end else begin
                            r_t     <= r_t + LEN_W'(1);
                            r_state <= ST_ACCEPT;
                        end
`else
                        r_state <= ST_EMIT;
`endif
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (bus.h_ready) begin
                        if (w_t_last) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_t     <= r_t + LEN_W'(1);
                            r_state <= ST_ACCEPT;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.x_ready   = (r_state == ST_ACCEPT);
    assign bus.cell_x    = r_x;
    assign bus.cell_c    = r_c;
    assign bus.cell_h    = r_h;
    assign bus.h_valid   = w_emit;
    assign bus.h_data    = r_h;
    assign bus.h_last    = w_emit && w_t_last;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lstm_seq_ctrl
// Directed bench for lstm_seq_ctrl with a stub cell
// (c_out = c_in + x, h_out = x). Runs the default build checks unless
// LSTM_LAST_ONLY_EN is defined, in which case the last-only scenario runs.
// -----------------------------------------------------------------------------
module tb_lstm_seq_ctrl;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int CL = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   hs_cnt;
  int   n_checks;
  int   n_errors;
  logic [DW-1:0] exp_q[$];

  lstm_seq_ctrl_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus ();

  lstm_seq_ctrl #(
    .DATA_WIDTH (DW),
    .FRACT_WIDTH(8),
    .LEN_W      (LW),
    .CELL_LAT   (CL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // stub lstm_cell
  assign bus.cell_c_out = bus.cell_c + bus.cell_x;
  assign bus.cell_h_out = bus.cell_x;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial hs_cnt = 0;
  always @(posedge clk) if (bus.h_valid === 1'b1 && bus.h_ready === 1'b1) hs_cnt <= hs_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input logic [LW-1:0] len);
    bus.start   = 1'b1;
    bus.seq_len = len;
    tick();
    bus.start   = 1'b0;
  endtask

  // Presents one sample, returns the cycle number of its handshake (-1 on timeout).
  task automatic send_x(input logic [DW-1:0] d, output int k);
    k = -1;
    bus.x_valid = 1'b1;
    bus.x_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (bus.x_ready === 1'b1) begin
        k = cyc;
        break;
      end
      tick();
    end
    chk("x_handshake_seen", 32'(k >= 0), 32'd1);
    if (k >= 0) tick();
    bus.x_valid = 1'b0;
  endtask

  // Waits for h_valid and checks rise cycle, data and last; completes the
  // handshake when h_ready is high.
  task automatic recv_h(input string tag, input logic [DW-1:0] exp_d,
                        input logic exp_last, input int exp_rise);
    int rise;
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.h_valid === 1'b1) begin
        rise = cyc;
        break;
      end
      tick();
    end
    chk({tag, "_rise"}, 32'(rise), 32'(exp_rise));
    chk({tag, "_data"}, 32'(bus.h_data), 32'(exp_d));
    chk({tag, "_last"}, 32'(bus.h_last), 32'(exp_last));
    chk({tag, "_xrdy"}, 32'(bus.x_ready), 32'd0);
    if (bus.h_ready === 1'b1 && rise >= 0) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),    32'd0);
    chk({tag, "_done"},   32'(bus.done),    32'd0);
    chk({tag, "_xrdy"},   32'(bus.x_ready), 32'd0);
    chk({tag, "_hvalid"}, 32'(bus.h_valid), 32'd0);
    chk({tag, "_hlast"},  32'(bus.h_last),  32'd0);
    chk({tag, "_hdata"},  32'(bus.h_data),  32'd0);
    chk({tag, "_cellx"},  32'(bus.cell_x),  32'd0);
    chk({tag, "_cellc"},  32'(bus.cell_c),  32'd0);
    chk({tag, "_cellh"},  32'(bus.cell_h),  32'd0);
    chk({tag, "_state"},  32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    int k;
    int kp;
    logic [DW-1:0] xs [3];
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.seq_len = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.h_ready = 1'b0;

    // ---- reset then idle ----
    repeat (3) tick();
    rst = 1'b0;
    chk_all_zero("reset");

    start_seq(8'd0);
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("len0_done_end", 32'(bus.done), 32'd0);
    chk("len0_busy_end", 32'(bus.busy), 32'd0);

`ifndef LSTM_LAST_ONLY_EN
    // ---- three-step sequence, h_ready held high ----
    bus.h_ready = 1'b1;
    xs[0] = 16'h0100; xs[1] = 16'h0200; xs[2] = 16'h0080;
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0200); exp_q.push_back(16'h0080);
    start_seq(8'd3);
    chk("seq3_busy", 32'(bus.busy), 32'd1);
    chk("seq3_xrdy", 32'(bus.x_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_x(xs[i], k);
      chk("seq3_wait_xrdy", 32'(bus.x_ready), 32'd0);
      recv_h("seq3_h", exp_q.pop_front(), logic'(i == 2), k + CL + 1);
    end
    chk("seq3_done", 32'(bus.done), 32'd1);
    chk("seq3_busy_end", 32'(bus.busy), 32'd0);
    chk("seq3_cell_c", 32'(bus.cell_c), 32'h0380);
    chk("seq3_cell_h", 32'(bus.cell_h), 32'h0080);
    chk("seq3_hs_cnt", 32'(hs_cnt), 32'd3);
    tick();
    chk("seq3_done_pulse", 32'(bus.done), 32'd0);

    // ---- backpressure, with a start pulse that must be ignored ----
    bus.h_ready = 1'b0;
    start_seq(8'd2);
    send_x(16'h0010, k);
    recv_h("bp_h0", 16'h0010, 1'b0, k + CL + 1);
    for (int j = 0; j < 5; j++) begin
      if (j == 1) begin
        bus.start   = 1'b1;
        bus.seq_len = 8'd1;
      end
      chk("bp_hvalid", 32'(bus.h_valid), 32'd1);
      chk("bp_hdata",  32'(bus.h_data),  32'h0010);
      chk("bp_hlast",  32'(bus.h_last),  32'd0);
      chk("bp_xrdy",   32'(bus.x_ready), 32'd0);
      tick();
      bus.start = 1'b0;
    end
    bus.h_ready = 1'b1;
    tick();
    chk("bp_accept_next", 32'(bus.x_ready), 32'd1);
    send_x(16'h0020, k);
    recv_h("bp_h1", 16'h0020, 1'b1, k + CL + 1);
    chk("bp_done", 32'(bus.done), 32'd1);
    chk("bp_cell_c", 32'(bus.cell_c), 32'h0030);
    tick();

    // second sequence starts from cleared state
    start_seq(8'd1);
    chk("seq1_cell_c_clr", 32'(bus.cell_c), 32'd0);
    chk("seq1_cell_h_clr", 32'(bus.cell_h), 32'd0);
    send_x(16'h0005, k);
    recv_h("seq1_h", 16'h0005, 1'b1, k + CL + 1);
    chk("seq1_done", 32'(bus.done), 32'd1);
    chk("seq1_cell_c", 32'(bus.cell_c), 32'h0005);
    tick();

    // ---- reset during WAIT of step 2 ----
    start_seq(8'd3);
    send_x(16'h0100, k);
    recv_h("rst_h0", 16'h0100, 1'b0, k + CL + 1);
    send_x(16'h0200, k);
    chk("rst_in_wait", 32'(bus.dbg_state), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("midrst");
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("midrst_no_done", 32'(bus.done), 32'd0);
      chk("midrst_idle", 32'(bus.busy), 32'd0);
    end
    start_seq(8'd2);
    send_x(16'h0300, k);
    recv_h("post_h0", 16'h0300, 1'b0, k + CL + 1);
    send_x(16'h0400, k);
    recv_h("post_h1", 16'h0400, 1'b1, k + CL + 1);
    chk("post_done", 32'(bus.done), 32'd1);
    chk("post_cell_c", 32'(bus.cell_c), 32'h0700);
    tick();
`else
    // ---- last-only: four steps, one h ----
    bus.h_ready = 1'b1;
    start_seq(8'd4);
    kp = -1;
    for (int i = 0; i < 4; i++) begin
      send_x(16'(16'h0011 * (i + 1)), k);
      if (i > 0) chk("lo_step_period", 32'(k - kp), 32'(CL + 1));
      if (i < 3) chk("lo_no_hvalid", 32'(bus.h_valid), 32'd0);
      kp = k;
    end
    recv_h("lo_h", 16'h0044, 1'b1, k + CL + 1);
    chk("lo_done", 32'(bus.done), 32'd1);
    chk("lo_hs_cnt", 32'(hs_cnt), 32'd1);
    chk("lo_cell_c", 32'(bus.cell_c), 32'h00aa);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
